// File: rtl/ps2_keyboard_tx.sv
// rtl/ps2_keyboard_tx.sv - PS/2 device-side keyboard transmitter with optional 0xF0 break prefix
//
// Accepts a scan code through a valid/ready handshake and sends it as an
// 11-bit PS/2 frame: start 0, data LSB first, odd parity, stop 1. When
// tx_break is set at acceptance, a 0xF0 frame is sent first.
//
// Ports:
//   clk           in   system clock, all logic on the rising edge
//   reset_n       in   asynchronous active-low reset
//   tx_valid      in   request present
//   tx_code[7:0]  in   scan code to send
//   tx_break      in   1: send 0xF0 before tx_code
//   tx_ready      out  idle, a request can be accepted
//   tx_done       out  one-cycle pulse when a request has fully completed
//   busy          out  request in progress (~tx_ready)
//   keyboard_clk  out  PS/2 clock, idle 1
//   keyboard_data out  PS/2 data, idle 1
module ps2_keyboard_tx #(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_CYCLES  = 4000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_code,
  input  logic       tx_break,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       busy,
  output logic       keyboard_clk,
  output logic       keyboard_data
);

  localparam int MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  // Counters are loaded with N-1 so each phase lasts exactly N cycles.
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX  = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    BIT_HI,
    BIT_LO,
    GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    idx_q;
  logic [7:0]    byte_q;    // byte of the frame currently on the wire
  logic [7:0]    code_q;    // scan code held for the frame after a break prefix
  logic          pend_q;    // a second frame still has to follow
  logic          kclk_q;
  logic          kdata_q;
  logic          ready_q;
  logic          done_q;
  logic          busy_q;
  logic          next_bit_d;

  // Frame bit k: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] k);
    logic [3:0] km1;
    logic       r;
    km1 = k - 4'd1;
    case (k)
      4'd0:    r = 1'b0;
      4'd9:    r = ~^b;
      4'd10:   r = 1'b1;
      default: r = b[km1[2:0]];
    endcase
    return r;
  endfunction

  // Next bit is computed ahead so it can be registered on the rising
  // keyboard_clk edge, keeping data stable across the whole low phase.
  always_comb begin
    next_bit_d = frame_bit(byte_q, idx_q + 4'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      byte_q  <= 8'h00;
      code_q  <= 8'h00;
      pend_q  <= 1'b0;
      kclk_q  <= 1'b1;
      kdata_q <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid && ready_q) begin
            byte_q  <= tx_break ? 8'hF0 : tx_code;
            code_q  <= tx_code;
            pend_q  <= tx_break;
            idx_q   <= 4'd0;
            cnt_q   <= HALF_LOAD;
            kclk_q  <= 1'b1;
            kdata_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= BIT_HI;
          end
        end
        BIT_HI: begin
          if (cnt_q == '0) begin
            kclk_q  <= 1'b0;
            cnt_q   <= HALF_LOAD;
            state_q <= BIT_LO;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        BIT_LO: begin
          if (cnt_q == '0) begin
            kclk_q <= 1'b1;
            if (idx_q != LAST_IDX) begin
              idx_q   <= idx_q + 4'd1;
              kdata_q <= next_bit_d;
              cnt_q   <= HALF_LOAD;
              state_q <= BIT_HI;
            end else begin
              kdata_q <= 1'b1;
              cnt_q   <= GAP_LOAD;
              state_q <= GAP;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            if (pend_q) begin
              byte_q  <= code_q;
              pend_q  <= 1'b0;
              idx_q   <= 4'd0;
              kdata_q <= 1'b0;
              cnt_q   <= HALF_LOAD;
              state_q <= BIT_HI;
            end else begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready      = ready_q;
  assign tx_done       = done_q;
  assign busy          = busy_q;
  assign keyboard_clk  = kclk_q;
  assign keyboard_data = kdata_q;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb/tb_ps2_keyboard_tx.sv - self-checking bench for ps2_keyboard_tx
module tb_ps2_keyboard_tx;

  localparam int H = 4;
  localparam int G = 8;
  localparam int FRAME = 22 * H + G;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_code = 8'h00;
  logic       tx_break = 1'b0;
  logic       tx_ready;
  logic       tx_done;
  logic       busy;
  logic       keyboard_clk;
  logic       keyboard_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic prev_kclk = 1'b1;
  logic prev_kdata = 1'b1;
  logic fall_q[$];
  int   fall_t[$];
  int   done_cnt = 0;
  int   glitch_cnt = 0;
  int   busy_err = 0;

  ps2_keyboard_tx #(.HALF_PERIOD(H), .GAP_CYCLES(G)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tx_valid      (tx_valid),
    .tx_code       (tx_code),
    .tx_break      (tx_break),
    .tx_ready      (tx_ready),
    .tx_done       (tx_done),
    .busy          (busy),
    .keyboard_clk  (keyboard_clk),
    .keyboard_data (keyboard_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the wire as a PS/2 host would: capture data at each falling clock.
  always @(negedge clk) begin
    if (prev_kclk === 1'b1 && keyboard_clk === 1'b0) begin
      fall_q.push_back(keyboard_data);
      fall_t.push_back(cyc);
    end
    if (keyboard_data !== prev_kdata && keyboard_clk !== 1'b1) glitch_cnt++;
    if (busy !== ~tx_ready) busy_err++;
    if (tx_done === 1'b1) done_cnt++;
    prev_kclk  = keyboard_clk;
    prev_kdata = keyboard_data;
  end

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic clear_mon();
    fall_q.delete();
    fall_t.delete();
  endtask

  task automatic send(input logic [7:0] code, input logic brk, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", 0, tx_ready, 1);
    tx_valid = 1'b1;
    tx_code  = code;
    tx_break = brk;
    @(negedge clk);
    acc = cyc;
    chk("ready_drop", 0, tx_ready, 0);
    tx_valid = 1'b0;
    tx_code  = 8'($urandom);
    tx_break = 1'($urandom);
  endtask

  task automatic wait_done(output int t, output int ready_hi);
    int n;
    n = 0;
    t = -1;
    ready_hi = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        t = cyc;
        break;
      end
      if (tx_ready === 1'b1) ready_hi++;
      n++;
    end
    chk("done_seen", 0, (t != -1), 1);
  endtask

  // Expected frames are built directly from the PS/2 frame rules.
  task automatic check_req(input logic [7:0] code, input logic brk, input int acc,
                           input int t, input int pre, input int rh);
    int nf;
    int fi;
    logic [7:0]  byt;
    logic [10:0] frame;
    logic [10:0] sh;
    nf = brk ? 2 : 1;
    chk("nfalls", 0, fall_q.size(), 11 * nf);
    for (int f = 0; f < nf; f++) begin
      byt = (brk && f == 0) ? 8'hF0 : code;
      frame = {1'b1, ~^byt, byt, 1'b0};
      for (int k = 0; k < 11; k++) begin
        fi = f * 11 + k;
        sh = frame >> k;
        if (fi < fall_q.size()) begin
          chk("bit", fi, fall_q[fi], sh[0]);
          chk("fall_time", fi, fall_t[fi], acc + f * FRAME + 2 * k * H + H);
        end
      end
    end
    chk("done_time", 0, t, acc + nf * FRAME);
    chk("done_count", 0, done_cnt, pre + 1);
    chk("ready_low_during", 0, rh, 0);
  endtask

  task automatic run_req(input logic [7:0] code, input logic brk);
    int acc, t, rh, pre;
    clear_mon();
    pre = done_cnt;
    send(code, brk, acc);
    wait_done(t, rh);
    @(negedge clk);
    chk("ready_after_done", 0, tx_ready, 1);
    chk("done_one_cycle", 0, tx_done, 0);
    check_req(code, brk, acc, t, pre, rh);
  endtask

  initial begin
    int acc, acc2, t, rh, pre, n;
    logic [7:0] a, b;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_kclk", 0, keyboard_clk, 1);
    chk("rst_kdata", 0, keyboard_data, 1);
    chk("rst_ready", 0, tx_ready, 1);
    chk("rst_done", 0, tx_done, 0);
    chk("rst_busy", 0, busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Make code, break code
    run_req(8'h1C, 1'b0);
    run_req(8'h1C, 1'b1);

    // Parity corners
    run_req(8'h00, 1'b0);
    run_req(8'h01, 1'b0);
    run_req(8'hFF, 1'b0);
    run_req(8'h80, 1'b0);

    // Handshake: valid held high, code changed after acceptance, back-to-back
    a = 8'($urandom);
    b = a ^ 8'h5A;
    clear_mon();
    pre = done_cnt;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_code  = a;
    tx_break = 1'b0;
    @(negedge clk);
    acc = cyc;
    chk("hs_ready_drop", 0, tx_ready, 0);
    tx_code = b;
    wait_done(t, rh);
    @(negedge clk);
    chk("hs_reaccept", 0, tx_ready, 0);
    check_req(a, 1'b0, acc, t, pre, rh);
    acc2 = t + 1;
    tx_valid = 1'b0;
    tx_code  = ~b;
    clear_mon();
    pre = done_cnt;
    wait_done(t, rh);
    @(negedge clk);
    check_req(b, 1'b0, acc2, t, pre, rh);

    // Reset mid-frame
    clear_mon();
    pre = done_cnt;
    send(8'h1C, 1'b0, acc);
    n = 0;
    while (fall_q.size() < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit5", 0, (fall_q.size() >= 5), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_kclk", 0, keyboard_clk, 1);
    chk("mid_rst_kdata", 0, keyboard_data, 1);
    chk("mid_rst_ready", 0, tx_ready, 1);
    chk("mid_rst_busy", 0, busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    chk("mid_rst_no_done", 0, done_cnt, pre);
    run_req(8'h1C, 1'b0);

    // Randomized requests
    for (int i = 0; i < 8; i++) begin
      run_req(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    chk("no_glitch", 0, glitch_cnt, 0);
    chk("busy_is_not_ready", 0, busy_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_tx.md
# ps2_keyboard_tx

Synthesizable PS/2 device-side transmitter that emulates a keyboard: it takes a scan code through a valid/ready handshake and drives `keyboard_clk`/`keyboard_data` with standard 11-bit PS/2 frames. On request it precedes the code with the 0xF0 break prefix. It is the transmitting counterpart of `keyboard_top`. It is used for on-board loopback of `keyboard_top` and as a reusable stimulus source in benches.

## Interface
- `HALF_PERIOD`, 2000: `keyboard_clk` half period in `clk` cycles. Minimum 2.
- `GAP_CYCLES`, 4000: idle cycles after every frame, with both lines high. Minimum 1.
- `clk`  in  1  system clock. One clock domain; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  a request is present.
- `tx_code`  in  8  scan code to send.
- `tx_break`  in  1  1: send 0xF0, then `tx_code`; 0: send `tx_code` only.
- `tx_ready`  out  1  block is idle and can accept a request.
- `tx_done`  out  1  one-cycle pulse when a request has fully completed.
- `busy`  out  1  a request is in progress (`~tx_ready`).
- `keyboard_clk`  out  1  PS/2 clock; idle level 1.
- `keyboard_data`  out  1  PS/2 data; idle level 1.

## Operation
- Reset values: `keyboard_clk`=1, `keyboard_data`=1, `tx_ready`=1, `tx_done`=0, `busy`=0, state IDLE.
- Reset mid-frame aborts the request at once. Both lines return to 1 and nothing is resumed.
- Acceptance happens on a rising edge where `tx_valid & tx_ready`. At that edge `tx_code` and `tx_break` are registered. Inputs are ignored at all other times.
- Frame format, LSB first: start 0, data[0..7], odd parity (`~^data`), stop 1. Total 11 bits.
- State machine:
  - IDLE: accept a request. Load byte 0xF0 if `tx_break`=1, otherwise load `tx_code`. Go to BIT_HI with bit index 0.
  - BIT_HI: `keyboard_clk`=1 and `keyboard_data` holds the current bit. After `HALF_PERIOD` cycles go to BIT_LO.
  - BIT_LO: `keyboard_clk`=0. After `HALF_PERIOD` cycles, if bit index < 10, increment the index and go to BIT_HI with the next bit. If the index is 10, set `keyboard_clk`=1 and `keyboard_data`=1 and go to GAP.
  - GAP: both lines stay at 1 for `GAP_CYCLES` cycles. Then, if a pending second byte exists (break case), load `tx_code`, index 0, go to BIT_HI. Otherwise pulse `tx_done` and go to IDLE.
- Data changes only while `keyboard_clk` is high, so every falling edge samples a bit that has been stable for `HALF_PERIOD` cycles.
- The down-counter is `$clog2(max(HALF_PERIOD, GAP_CYCLES))+1` bits wide. The parity and shift register are 8 bits plus a 4-bit index.

## Timing
- All outputs are registered. Edge 0 is the acceptance edge; H=`HALF_PERIOD`, G=`GAP_CYCLES`.
- Frame bit k (0..10) is driven from edge 2kH. `keyboard_clk` falls at edge 2kH+H and rises at edge 2(k+1)H.
- The start bit (0) appears at edge 0 and `tx_ready` drops at edge 0.
- At edge 22H the lines return to idle (1,1).
- Single-byte request: `tx_done`=1 for the one cycle starting at edge 22H+G, and `tx_ready`=1 from the same edge. A new request can be accepted at edge 22H+G+1.
- Break request: the second frame's start bit is driven at edge 22H+G, and `tx_done` fires at edge 44H+2G.
- Each frame has exactly 11 falling `keyboard_clk` edges. No glitches are allowed on either line.

## Test plan
- Make code: `tx_code`=0x1C, `tx_break`=0, H=4, G=8. The bits at the falling edges must read 0,0,0,1,1,1,0,0,0,0,1 (parity 0). `tx_done` fires at edge 96 and there are 11 falling edges in total.
- Break: `tx_code`=0x1C, `tx_break`=1. The first frame must read 0,0,0,0,0,1,1,1,1,1,1 (0xF0, parity 1) and the second frame must match the make-code case. `tx_done` fires once at edge 44H+2G, and `tx_ready` stays low in between.
- Parity corners: 0x00 gives parity 1, 0x01 gives parity 0, 0xFF gives parity 1, 0x80 gives parity 0, all checked at the 10th falling edge.
- Handshake: hold `tx_valid`=1 and change `tx_code` during a frame. The transmitted byte must equal the value at acceptance. Back-to-back requests must each be separated by at least G idle cycles.
- Reset mid-frame: assert `reset_n`=0 at bit 5. Both lines must be 1 and `tx_ready`=1 immediately, with no `tx_done`. After release, a fresh request for 0x1C must transmit correctly.
- Loopback: connect the outputs to `keyboard_top` with H=2000 and a 50 MHz `clk`. Send 12 codes alternating make and break. `led_scancode_debug` must equal each sent code after its frame.
